// File: rtl/multicycle_control.sv
// Multi-cycle control sequencer for the MIPS32 shared-datapath core.
// Walks each instruction through fetch/decode/execute/memory/writeback
// states and drives the datapath mux selects and write enables. The
// memory states stall until the unified memory port reports ready.
//
// Ports:
//   clk, reset  - system clock, synchronous active-high reset
//   opcode      - IR[31:26], sampled in DECODE and MEMADR
//   mem_ready   - memory port completes the current access this cycle
//   pc_write, branch, iord, mem_read, mem_write, ir_write, reg_dst,
//   mem_to_reg, reg_write, alu_src_a, alu_src_b, alu_op, pc_src
//               - datapath controls decoded from the current state
//   instr_done  - pulse on the final cycle of an instruction
//   illegal_op  - pulse in DECODE for an unsupported opcode
//   state       - current state code, for debug
module multicycle_control #(
  parameter int unsigned OPCODE_W = 6
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [OPCODE_W-1:0] opcode,
  input  logic                mem_ready,
  output logic                pc_write,
  output logic                branch,
  output logic                iord,
  output logic                mem_read,
  output logic                mem_write,
  output logic                ir_write,
  output logic                reg_dst,
  output logic                mem_to_reg,
  output logic                reg_write,
  output logic                alu_src_a,
  output logic [1:0]          alu_src_b,
  output logic [1:0]          alu_op,
  output logic [1:0]          pc_src,
  output logic                instr_done,
  output logic                illegal_op,
  output logic [3:0]          state
);

  localparam logic [OPCODE_W-1:0] OpRtype = OPCODE_W'(6'b000000);
  localparam logic [OPCODE_W-1:0] OpLw    = OPCODE_W'(6'b100011);
  localparam logic [OPCODE_W-1:0] OpSw    = OPCODE_W'(6'b101011);
  localparam logic [OPCODE_W-1:0] OpBeq   = OPCODE_W'(6'b000100);
  localparam logic [OPCODE_W-1:0] OpAddi  = OPCODE_W'(6'b001000);
  localparam logic [OPCODE_W-1:0] OpJ     = OPCODE_W'(6'b000010);

  typedef enum logic [3:0] {
    StFetch   = 4'd0,
    StDecode  = 4'd1,
    StMemAdr  = 4'd2,
    StMemRd   = 4'd3,
    StMemWb   = 4'd4,
    StMemWr   = 4'd5,
    StExecute = 4'd6,
    StAluWb   = 4'd7,
    StBeq     = 4'd8,
    StAddiEx  = 4'd9,
    StAddiWb  = 4'd10,
    StJump    = 4'd11
  } state_e;

  state_e state_q, state_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StFetch;
    end else begin
      state_q <= state_d;
    end
  end

  assign state = state_q;

  always_comb begin
    state_d    = state_q;
    pc_write   = 1'b0;
    branch     = 1'b0;
    iord       = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    ir_write   = 1'b0;
    reg_dst    = 1'b0;
    mem_to_reg = 1'b0;
    reg_write  = 1'b0;
    alu_src_a  = 1'b0;
    alu_src_b  = 2'b00;
    alu_op     = 2'b00;
    pc_src     = 2'b00;
    instr_done = 1'b0;
    illegal_op = 1'b0;

    case (state_q)
      StFetch: begin
        mem_read  = 1'b1;
        alu_src_b = 2'b01;
        ir_write  = mem_ready;
        pc_write  = mem_ready;
        if (mem_ready) begin
          state_d = StDecode;
        end
      end
      StDecode: begin
        alu_src_b = 2'b11;
        case (opcode)
          OpRtype:    state_d = StExecute;
          OpLw, OpSw: state_d = StMemAdr;
          OpBeq:      state_d = StBeq;
          OpAddi:     state_d = StAddiEx;
          OpJ:        state_d = StJump;
          default: begin
            state_d    = StFetch;
            illegal_op = 1'b1;
          end
        endcase
      end
      StMemAdr: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        state_d   = (opcode == OpLw) ? StMemRd : StMemWr;
      end
      StMemRd: begin
        iord     = 1'b1;
        mem_read = 1'b1;
        if (mem_ready) begin
          state_d = StMemWb;
        end
      end
      StMemWb: begin
        mem_to_reg = 1'b1;
        reg_write  = 1'b1;
        instr_done = 1'b1;
        state_d    = StFetch;
      end
      StMemWr: begin
        iord      = 1'b1;
        mem_write = 1'b1;
        if (mem_ready) begin
          instr_done = 1'b1;
          state_d    = StFetch;
        end
      end
      StExecute: begin
        alu_src_a = 1'b1;
        alu_op    = 2'b10;
        state_d   = StAluWb;
      end
      StAluWb: begin
        reg_dst    = 1'b1;
        reg_write  = 1'b1;
        instr_done = 1'b1;
        state_d    = StFetch;
      end
      StBeq: begin
        alu_src_a  = 1'b1;
        alu_op     = 2'b01;
        pc_src     = 2'b01;
        branch     = 1'b1;
        instr_done = 1'b1;
        state_d    = StFetch;
      end
      StAddiEx: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        state_d   = StAddiWb;
      end
      StAddiWb: begin
        reg_write  = 1'b1;
        instr_done = 1'b1;
        state_d    = StFetch;
      end
      StJump: begin
        pc_src     = 2'b10;
        pc_write   = 1'b1;
        instr_done = 1'b1;
        state_d    = StFetch;
      end
      // Codes 12-15 are unreachable; recover to fetch.
      default: state_d = StFetch;
    endcase

    // During reset the outputs look like an idle FETCH: every enable is
    // suppressed so an aborted instruction cannot write anything.
    if (reset) begin
      pc_write   = 1'b0;
      branch     = 1'b0;
      iord       = 1'b0;
      mem_read   = 1'b0;
      mem_write  = 1'b0;
      ir_write   = 1'b0;
      reg_dst    = 1'b0;
      mem_to_reg = 1'b0;
      reg_write  = 1'b0;
      alu_src_a  = 1'b0;
      alu_src_b  = 2'b01;
      alu_op     = 2'b00;
      pc_src     = 2'b00;
      instr_done = 1'b0;
      illegal_op = 1'b0;
    end
  end

endmodule
